// File: rtl/enemy_ai_pkg.sv
// Shared enemy definitions: state codes, keycodes and timer helpers.
// Used by the enemy AI, the enemy datapath and the sprite logic.
package enemy_ai_pkg;

  localparam int TIMER_W = 8;

  typedef logic [6:0] enemyState_t;

  localparam enemyState_t ST_IDLE     = 7'd0;
  localparam enemyState_t ST_APPROACH = 7'd1;
  localparam enemyState_t ST_GUARD    = 7'd2;
  localparam enemyState_t ST_ATTACK   = 7'd3;
  localparam enemyState_t ST_STUN     = 7'd4;
  localparam enemyState_t ST_DEATH    = 7'd5;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_PUNCH = 8'h0D;
  localparam logic [7:0] KEY_NONE  = 8'h00;

  // Distance that can never wrap: always subtract the smaller from the larger.
  function automatic logic [9:0] absDiff(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // A timer spends its final frame at count 1, so it expires on the edge leaving that frame.
  function automatic logic timerLast(input logic [TIMER_W-1:0] cnt, input logic zero);
    return zero || (cnt == TIMER_W'(1));
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Per-frame down counter: synchronous clear, load, saturating decrement, zero flag.
module frame_timer
  import enemy_ai_pkg::*;
#(
  parameter int unsigned RESET_VAL = 0
) (
  input  logic               frame_clk,
  input  logic               Reset_n,
  input  logic               clear,
  input  logic               load,
  input  logic [TIMER_W-1:0] loadVal,
  input  logic               dec,
  output logic [TIMER_W-1:0] count,
  output logic               zero
);

  logic [TIMER_W-1:0] count_r;

  // Counter register; clear beats load, load beats decrement.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_r <= TIMER_W'(RESET_VAL);
    end else if (clear) begin
      count_r <= TIMER_W'(0);
    end else if (load) begin
      count_r <= loadVal;
    end else if (dec && (count_r != TIMER_W'(0))) begin
      count_r <= count_r - TIMER_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == TIMER_W'(0));

endmodule

// File: rtl/enemy_ai.sv
// Enemy behaviour FSM: approach the hero, guard, punch, get stunned, die.
// All outputs are registered and describe the state entered at the same edge.
module enemy_ai
  import enemy_ai_pkg::*;
#(
  parameter int unsigned ATTACK_DIST = 40,
  parameter int unsigned ATTACK_LEN  = 12,
  parameter int unsigned COOLDOWN    = 30,
  parameter int unsigned STUN_LEN    = 15,
  parameter int unsigned HEALTH_INIT = 4
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       game_active,
  input  logic [9:0] HeroX,
  input  logic [9:0] EnemyX,
  input  logic       hero_hit,
  output logic [7:0] keycode,
  output logic [6:0] EnemyS,
  output logic       enemy_strike,
  output logic [2:0] health,
  output logic       enemy_dead
);

  localparam logic [9:0]         ATK_DIST_C = 10'(ATTACK_DIST);
  localparam logic [TIMER_W-1:0] ATK_LEN_C  = TIMER_W'(ATTACK_LEN);
  localparam logic [TIMER_W-1:0] COOL_C     = TIMER_W'(COOLDOWN);
  localparam logic [TIMER_W-1:0] STUN_C     = TIMER_W'(STUN_LEN);
  // Count value held during attack frame ATTACK_LEN/2 (frame k holds ATTACK_LEN-k+1).
  localparam logic [TIMER_W-1:0] STRIKE_CNT = TIMER_W'(ATTACK_LEN - ATTACK_LEN / 2 + 1);

  enemyState_t        state_r, nextState_s;
  logic [7:0]         keycode_r, keyNext_s;
  logic               strike_r, strikeNext_s, dead_r;
  logic [2:0]         health_r, healthNext_s;
  logic [9:0]         dist_s;
  logic [7:0]         toward_s;
  logic               inRange_s, engaged_s, hitTaken_s;
  logic               coolLoad_s, coolDec_s, atkLoad_s, atkDec_s, atkClear_s;
  logic               stunLoad_s, stunDec_s, stunClear_s;
  logic [TIMER_W-1:0] coolCnt_s, atkCnt_s, stunCnt_s, atkNext_s;
  logic               coolZero_s, atkZero_s, stunZero_s;

  assign dist_s     = absDiff(HeroX, EnemyX);
  assign toward_s   = (EnemyX > HeroX) ? KEY_LEFT : KEY_RIGHT;
  assign inRange_s  = (dist_s <= ATK_DIST_C);
  assign engaged_s  = (state_r == ST_APPROACH) || (state_r == ST_GUARD) ||
                      (state_r == ST_ATTACK)   || (state_r == ST_STUN);
  assign hitTaken_s = hero_hit && game_active &&
                      ((state_r == ST_APPROACH) || (state_r == ST_GUARD) || (state_r == ST_ATTACK));

  // Next-state and timer control; leaving play wins over a hit, a hit wins over normal flow.
  always_comb begin
    nextState_s  = state_r;
    healthNext_s = health_r;
    coolLoad_s   = 1'b0;
    coolDec_s    = 1'b0;
    atkLoad_s    = 1'b0;
    atkDec_s     = 1'b0;
    atkClear_s   = 1'b0;
    stunLoad_s   = 1'b0;
    stunDec_s    = 1'b0;
    stunClear_s  = 1'b0;
    if (engaged_s && !game_active) begin
      nextState_s = ST_IDLE;
      coolLoad_s  = 1'b1;
      atkClear_s  = 1'b1;
      stunClear_s = 1'b1;
    end else if (hitTaken_s) begin
      healthNext_s = (health_r != 3'd0) ? (health_r - 3'd1) : 3'd0;
      atkClear_s   = 1'b1;
      if (health_r <= 3'd1) begin
        nextState_s = ST_DEATH;
        stunClear_s = 1'b1;
      end else begin
        nextState_s = ST_STUN;
        stunLoad_s  = 1'b1;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (game_active) nextState_s = ST_APPROACH;
          else             nextState_s = ST_IDLE;
        end
        ST_APPROACH: begin
          if (inRange_s) nextState_s = ST_GUARD;
          else           nextState_s = ST_APPROACH;
        end
        ST_GUARD: begin
          coolDec_s = 1'b1;
          if (!inRange_s) begin
            nextState_s = ST_APPROACH;
          end else if (timerLast(coolCnt_s, coolZero_s)) begin
            nextState_s = ST_ATTACK;
            atkLoad_s   = 1'b1;
          end else begin
            nextState_s = ST_GUARD;
          end
        end
        ST_ATTACK: begin
          if (timerLast(atkCnt_s, atkZero_s)) begin
            nextState_s = ST_GUARD;
            coolLoad_s  = 1'b1;
            atkClear_s  = 1'b1;
          end else begin
            nextState_s = ST_ATTACK;
            atkDec_s    = 1'b1;
          end
        end
        ST_STUN: begin
          if (timerLast(stunCnt_s, stunZero_s)) begin
            nextState_s = ST_GUARD;
            coolLoad_s  = 1'b1;
            stunClear_s = 1'b1;
          end else begin
            nextState_s = ST_STUN;
            stunDec_s   = 1'b1;
          end
        end
        ST_DEATH: nextState_s = ST_DEATH;
        default:  nextState_s = ST_IDLE;
      endcase
    end
  end

  // Output decode from the state about to be entered.
  always_comb begin
    keyNext_s = KEY_NONE;
    atkNext_s = ATK_LEN_C;
    if (state_r == ST_ATTACK) atkNext_s = atkCnt_s - TIMER_W'(1);
    else                      atkNext_s = ATK_LEN_C;
    case (nextState_s)
      ST_APPROACH: keyNext_s = toward_s;
      ST_ATTACK:   keyNext_s = KEY_PUNCH;
      default:     keyNext_s = KEY_NONE;
    endcase
    strikeNext_s = (nextState_s == ST_ATTACK) && inRange_s && (atkNext_s == STRIKE_CNT);
  end

  // State and registered outputs.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= ST_IDLE;
      keycode_r <= KEY_NONE;
      strike_r  <= 1'b0;
      health_r  <= 3'(HEALTH_INIT);
      dead_r    <= 1'b0;
    end else begin
      state_r   <= nextState_s;
      keycode_r <= keyNext_s;
      strike_r  <= strikeNext_s;
      health_r  <= healthNext_s;
      dead_r    <= (nextState_s == ST_DEATH);
    end
  end

  frame_timer #(.RESET_VAL(COOLDOWN)) coolTimer (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .clear(1'b0), .load(coolLoad_s),
    .loadVal(COOL_C), .dec(coolDec_s), .count(coolCnt_s), .zero(coolZero_s)
  );

  frame_timer #(.RESET_VAL(0)) atkTimer (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .clear(atkClear_s), .load(atkLoad_s),
    .loadVal(ATK_LEN_C), .dec(atkDec_s), .count(atkCnt_s), .zero(atkZero_s)
  );

  frame_timer #(.RESET_VAL(0)) stunTimer (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .clear(stunClear_s), .load(stunLoad_s),
    .loadVal(STUN_C), .dec(stunDec_s), .count(stunCnt_s), .zero(stunZero_s)
  );

  assign keycode      = keycode_r;
  assign EnemyS       = state_r;
  assign enemy_strike = strike_r;
  assign health       = health_r;
  assign enemy_dead   = dead_r;

endmodule

// File: tb/tb_enemy_ai.sv
// Directed bench for enemy_ai: vector table for movement, hand sequences for
// cooldown/attack/stun/death timing and asynchronous reset.
module tb_enemy_ai;
  import enemy_ai_pkg::*;

  logic       frame_clk = 1'b0;
  logic       Reset_n;
  logic       game_active;
  logic [9:0] HeroX, EnemyX;
  logic       hero_hit;
  logic [7:0] keycode;
  logic [6:0] EnemyS;
  logic       enemy_strike;
  logic [2:0] health;
  logic       enemy_dead;

  int compared = 0;
  int failed   = 0;

  enemy_ai dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .game_active(game_active),
    .HeroX(HeroX), .EnemyX(EnemyX), .hero_hit(hero_hit),
    .keycode(keycode), .EnemyS(EnemyS), .enemy_strike(enemy_strike),
    .health(health), .enemy_dead(enemy_dead)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic       ga;
    logic [9:0] hx;
    logic [9:0] ex;
    logic       hit;
    logic [7:0] kc;
    logic [6:0] st;
    logic [2:0] hp;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] kc, input logic [6:0] st,
                          input logic stk, input logic [2:0] hp, input logic dead);
    chk({tag, " keycode"}, 32'(keycode), 32'(kc));
    chk({tag, " EnemyS"}, 32'(EnemyS), 32'(st));
    chk({tag, " strike"}, 32'(enemy_strike), 32'(stk));
    chk({tag, " health"}, 32'(health), 32'(hp));
    chk({tag, " dead"}, 32'(enemy_dead), 32'(dead));
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  // GUARD entered on the previous edge: 29 more GUARD frames, then attack frame 1.
  task automatic guardPhase(input logic [2:0] hp);
    for (int i = 2; i <= 30; i++) begin
      step();
      checkAll($sformatf("guard f%0d", i), 8'h00, ST_GUARD, 1'b0, hp, 1'b0);
    end
    step();
    checkAll("attack f1", 8'h0D, ST_ATTACK, 1'b0, hp, 1'b0);
  endtask

  task automatic attackRun(input int fromF, input int toF, input int strikeF, input logic [2:0] hp);
    for (int k = fromF; k <= toF; k++) begin
      step();
      checkAll($sformatf("attack f%0d", k), 8'h0D, ST_ATTACK, (k == strikeF), hp, 1'b0);
    end
  endtask

  // STUN entered on the previous edge: frames 2..15 stunned, then GUARD.
  task automatic stunPhase(input logic [2:0] hp, input int ignoreAt);
    for (int i = 2; i <= 15; i++) begin
      if (i == ignoreAt) hero_hit = 1'b1;
      step();
      hero_hit = 1'b0;
      checkAll($sformatf("stun f%0d", i), 8'h00, ST_STUN, 1'b0, hp, 1'b0);
    end
    step();
    checkAll("stun exit", 8'h00, ST_GUARD, 1'b0, hp, 1'b0);
  endtask

  task automatic hitToStun(input logic [2:0] hp);
    hero_hit = 1'b1;
    step();
    hero_hit = 1'b0;
    checkAll("hit stun", 8'h00, ST_STUN, 1'b0, hp, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 10'd100,  10'd540,  1'b0, 8'h00, ST_IDLE,     3'd4};
    vecs[1]  = '{1'b1, 10'd100,  10'd540,  1'b0, 8'h04, ST_APPROACH, 3'd4};
    vecs[2]  = '{1'b1, 10'd100,  10'd300,  1'b0, 8'h04, ST_APPROACH, 3'd4};
    vecs[3]  = '{1'b1, 10'd100,  10'd141,  1'b0, 8'h04, ST_APPROACH, 3'd4};
    vecs[4]  = '{1'b1, 10'd100,  10'd140,  1'b0, 8'h00, ST_GUARD,    3'd4};
    vecs[5]  = '{1'b1, 10'd100,  10'd141,  1'b0, 8'h04, ST_APPROACH, 3'd4};
    vecs[6]  = '{1'b0, 10'd100,  10'd141,  1'b0, 8'h00, ST_IDLE,     3'd4};
    vecs[7]  = '{1'b1, 10'd300,  10'd300,  1'b0, 8'h07, ST_APPROACH, 3'd4};
    vecs[8]  = '{1'b1, 10'd300,  10'd300,  1'b0, 8'h00, ST_GUARD,    3'd4};
    vecs[9]  = '{1'b1, 10'd500,  10'd200,  1'b0, 8'h07, ST_APPROACH, 3'd4};
    vecs[10] = '{1'b1, 10'd0,    10'd1023, 1'b0, 8'h04, ST_APPROACH, 3'd4};
    vecs[11] = '{1'b1, 10'd1023, 10'd0,    1'b0, 8'h07, ST_APPROACH, 3'd4};
    vecs[12] = '{1'b1, 10'd200,  10'd241,  1'b0, 8'h04, ST_APPROACH, 3'd4};
    vecs[13] = '{1'b1, 10'd241,  10'd200,  1'b0, 8'h07, ST_APPROACH, 3'd4};
    vecs[14] = '{1'b0, 10'd241,  10'd200,  1'b1, 8'h00, ST_IDLE,     3'd4};
    vecs[15] = '{1'b0, 10'd241,  10'd200,  1'b1, 8'h00, ST_IDLE,     3'd4};
    vecs[16] = '{1'b1, 10'd300,  10'd260,  1'b0, 8'h07, ST_APPROACH, 3'd4};
    vecs[17] = '{1'b1, 10'd300,  10'd260,  1'b0, 8'h00, ST_GUARD,    3'd4};
    vecs[18] = '{1'b0, 10'd300,  10'd260,  1'b0, 8'h00, ST_IDLE,     3'd4};

    Reset_n = 1'b1; game_active = 1'b0; HeroX = 10'd0; EnemyX = 10'd0; hero_hit = 1'b0;
    #1 Reset_n = 1'b0;
    #2 checkAll("reset", 8'h00, ST_IDLE, 1'b0, 3'd4, 1'b0);
    @(negedge frame_clk);
    Reset_n = 1'b1;

    for (int v = 0; v < 19; v++) begin
      game_active = vecs[v].ga; HeroX = vecs[v].hx; EnemyX = vecs[v].ex; hero_hit = vecs[v].hit;
      step();
      checkAll($sformatf("vec%0d", v), vecs[v].kc, vecs[v].st, 1'b0, vecs[v].hp, 1'b0);
    end
    hero_hit = 1'b0;

    // Full cooldown and attack with one strike at frame 6.
    game_active = 1'b1; HeroX = 10'd100; EnemyX = 10'd120;
    step(); checkAll("seqA approach", 8'h04, ST_APPROACH, 1'b0, 3'd4, 1'b0);
    step(); checkAll("seqA guard", 8'h00, ST_GUARD, 1'b0, 3'd4, 1'b0);
    guardPhase(3'd4);
    attackRun(2, 12, 6, 3'd4);
    step(); checkAll("seqA back to guard", 8'h00, ST_GUARD, 1'b0, 3'd4, 1'b0);

    // Hit during attack frame 3: no strike, 15 frames stunned, hit during stun ignored.
    guardPhase(3'd4);
    attackRun(2, 3, 6, 3'd4);
    hitToStun(3'd3);
    stunPhase(3'd3, 5);

    // Remaining hits until death, each more than 15 frames apart.
    hitToStun(3'd2);
    stunPhase(3'd2, 0);
    hitToStun(3'd1);
    stunPhase(3'd1, 0);
    hero_hit = 1'b1;
    step();
    checkAll("death", 8'h00, ST_DEATH, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      hero_hit = i[0]; game_active = i[1]; EnemyX = 10'd900;
      step();
      checkAll($sformatf("dead hold%0d", i), 8'h00, ST_DEATH, 1'b0, 3'd0, 1'b1);
    end
    hero_hit = 1'b0;

    // Out-of-range strike frame, then reset in the middle of a striking frame.
    #1 Reset_n = 1'b0;
    #1 checkAll("reset from death", 8'h00, ST_IDLE, 1'b0, 3'd4, 1'b0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    game_active = 1'b1; HeroX = 10'd100; EnemyX = 10'd120;
    step(); checkAll("seqC approach", 8'h04, ST_APPROACH, 1'b0, 3'd4, 1'b0);
    step(); checkAll("seqC guard", 8'h00, ST_GUARD, 1'b0, 3'd4, 1'b0);
    guardPhase(3'd4);
    attackRun(2, 5, 6, 3'd4);
    EnemyX = 10'd220;
    attackRun(6, 6, 0, 3'd4);
    EnemyX = 10'd120;
    attackRun(7, 12, 0, 3'd4);
    step(); checkAll("seqC guard again", 8'h00, ST_GUARD, 1'b0, 3'd4, 1'b0);
    guardPhase(3'd4);
    attackRun(2, 6, 6, 3'd4);
    #3 Reset_n = 1'b0;
    #1 checkAll("reset mid attack", 8'h00, ST_IDLE, 1'b0, 3'd4, 1'b0);
    @(negedge frame_clk);
    Reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
